// File: rtl/udp_frame_pkg.sv
// rtl/udp_frame_pkg.sv - shared constants and types for the UDP frame builder
//
// Purpose: header size, default TTL, per-frame status encoding, output FSM
//          states and the committed-frame descriptor layout.
// Ports:   none (package).

package udp_frame_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int DEFAULT_TTL   = 64;

  // Outcome of an input frame, decided in the cycle its s_tlast is accepted.
  typedef enum logic [1:0] {
    STATUS_NONE     = 2'd0,
    STATUS_GOOD     = 2'd1,
    STATUS_BAD      = 2'd2,
    STATUS_OVERFLOW = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_e;

  // Everything the output side needs for one committed frame.
  typedef struct packed {
    logic [15:0] length;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } udp_desc_t;

endpackage

// File: rtl/udp_frame_meta_fifo.sv
// rtl/udp_frame_meta_fifo.sv - descriptor FIFO for committed frames
//
// Purpose: small synchronous FIFO with a combinational head read; the head
//          stays visible until popped, so it can drive header fields directly.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          i_push/i_data - write side; pushes while full are ignored
//          o_full        - no free slot
//          i_pop/o_data  - read side; o_data is the current head
//          o_empty       - no committed descriptor

module udp_frame_meta_fifo
  import udp_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/udp_frame_builder.sv
// rtl/udp_frame_builder.sv - store-and-forward UDP header + payload builder
//
// Purpose: buffers each input payload frame, and only after its last byte is
//          committed emits a UDP/IP header followed by the stored payload.
//          Bad frames (s_tuser at s_tlast) and oversized frames are dropped.
// Ports:   clk, rst                        - clock, synchronous active-high reset
//          local_ip/dest_ip/source_port/dest_port - addressing, sampled at commit
//          s_tdata/s_tvalid/s_tready/s_tlast/s_tuser - payload input stream
//          tx_udp_hdr_*                    - header handshake and fields
//          tx_udp_payload_axis_*           - payload output stream
//          status_good_frame/status_bad_frame/status_overflow - one-cycle pulses
//          stat_frames_sent/stat_frames_dropped - saturating counters, present
//                                            only with UDP_FRAME_BUILDER_STATS_EN

module udp_frame_builder
  import udp_frame_pkg::*;
#(
  parameter int DEPTH       = 2048,
  parameter int MAX_PAYLOAD = 1472,
  parameter int META_DEPTH  = 16,
  parameter int TTL         = DEFAULT_TTL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] source_port,
  input  logic [15:0] dest_port,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic        tx_udp_hdr_valid,
  input  logic        tx_udp_hdr_ready,
  output logic [5:0]  tx_udp_ip_dscp,
  output logic [1:0]  tx_udp_ip_ecn,
  output logic [7:0]  tx_udp_ip_ttl,
  output logic [31:0] tx_udp_ip_source_ip,
  output logic [31:0] tx_udp_ip_dest_ip,
  output logic [15:0] tx_udp_source_port,
  output logic [15:0] tx_udp_dest_port,
  output logic [15:0] tx_udp_length,
  output logic [15:0] tx_udp_checksum,
  output logic [7:0]  tx_udp_payload_axis_tdata,
  output logic        tx_udp_payload_axis_tvalid,
  input  logic        tx_udp_payload_axis_tready,
  output logic        tx_udp_payload_axis_tlast,
  output logic        tx_udp_payload_axis_tuser,
  output logic        status_good_frame,
  output logic        status_bad_frame,
  output logic        status_overflow
`ifdef UDP_FRAME_BUILDER_STATS_EN
  ,
  output logic [31:0] stat_frames_sent,
  output logic [31:0] stat_frames_dropped
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // ---------------- input side ----------------
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_frame_start;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [15:0]      r_cnt;
  logic             r_drop;
  status_e          r_status;
  status_e          w_status;
  logic [PTR_W-1:0] w_used;
  logic             w_buf_full;
  logic             w_too_big;
  logic             w_in_fire;
  logic             w_wr_en;
  logic             w_commit;

  // ---------------- output side ----------------
  udp_desc_t        w_desc_in;
  udp_desc_t        w_desc_q;
  logic             w_meta_full;
  logic             w_meta_empty;
  logic             w_meta_pop;
  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic             w_hdr_start;
  logic [15:0]      r_rem;
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             w_load;
  logic             w_out_fire;

  // Drop state keeps absorbing bytes even if the descriptor FIFO is full,
  // since a dropped frame never needs a descriptor slot.
  assign s_tready   = r_drop || !w_meta_full;
  assign w_in_fire  = s_tvalid && s_tready;
  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_buf_full = (w_used == PTR_W'(DEPTH));
  // The next byte would exceed the payload limit or the free buffer space.
  assign w_too_big  = (r_cnt == 16'(MAX_PAYLOAD)) || w_buf_full;
  assign w_wr_en    = w_in_fire && !r_drop && !w_too_big;

  always_comb begin
    w_status = STATUS_NONE;
    if (w_in_fire && s_tlast) begin
      if (r_drop || w_too_big) w_status = STATUS_OVERFLOW;
      else if (s_tuser)        w_status = STATUS_BAD;
      else                     w_status = STATUS_GOOD;
    end
  end

  assign w_commit = (w_status == STATUS_GOOD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_frame_start <= '0;
      r_cnt         <= '0;
      r_drop        <= 1'b0;
      r_status      <= STATUS_NONE;
    end else begin
      r_status <= w_status;
      if (w_in_fire) begin
        if (s_tlast) begin
          r_cnt  <= '0;
          r_drop <= 1'b0;
          if (w_commit) begin
            r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
            r_frame_start <= r_wr_ptr + PTR_W'(1);
          end else begin
            r_wr_ptr <= r_frame_start;
          end
        end else if (r_drop || w_too_big) begin
          r_drop <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          r_cnt    <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign status_good_frame = (r_status == STATUS_GOOD);
  assign status_bad_frame  = (r_status == STATUS_BAD);
  assign status_overflow   = (r_status == STATUS_OVERFLOW);

  // Length counts the committing byte itself plus the UDP header.
  assign w_desc_in.length   = r_cnt + 16'(UDP_HDR_BYTES + 1);
  assign w_desc_in.src_ip   = local_ip;
  assign w_desc_in.dst_ip   = dest_ip;
  assign w_desc_in.src_port = source_port;
  assign w_desc_in.dst_port = dest_port;

  // The head descriptor stays in the FIFO until its payload completes, so
  // header fields are stable for the whole frame without a copy.
  udp_frame_meta_fifo #(
    .WIDTH ($bits(udp_desc_t)),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_data  (w_desc_in),
    .o_full  (w_meta_full),
    .i_pop   (w_meta_pop),
    .o_data  (w_desc_q),
    .o_empty (w_meta_empty)
  );

  // ---------------- output FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hdr_start      = 1'b0;
    w_meta_pop       = 1'b0;
    tx_udp_hdr_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_meta_empty) begin
          w_state_nxt = ST_HDR;
          w_hdr_start = 1'b1;
        end
      end
      ST_HDR: begin
        tx_udp_hdr_valid = 1'b1;
        if (tx_udp_hdr_ready) w_state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_out_fire && r_tlast) begin
          w_state_nxt = ST_IDLE;
          w_meta_pop  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-entry output register refilled from RAM whenever it is empty or
  // being drained, giving one byte per cycle with tready held high.
  assign w_out_fire = r_tvalid && tx_udp_payload_axis_tready;
  assign w_load     = (r_state == ST_PAYLOAD) && (r_rem != 16'd0) &&
                      (!r_tvalid || tx_udp_payload_axis_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_rem    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_hdr_start) r_rem <= w_desc_q.length - 16'(UDP_HDR_BYTES);
      else if (w_load) r_rem <= r_rem - 16'd1;
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_tvalid <= 1'b1;
        r_tlast  <= (r_rem == 16'd1);
      end else if (w_out_fire) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= s_tdata;
    if (w_load)  r_tdata <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  assign tx_udp_ip_dscp             = 6'd0;
  assign tx_udp_ip_ecn              = 2'd0;
  assign tx_udp_ip_ttl              = 8'(TTL);
  assign tx_udp_ip_source_ip        = w_desc_q.src_ip;
  assign tx_udp_ip_dest_ip          = w_desc_q.dst_ip;
  assign tx_udp_source_port         = w_desc_q.src_port;
  assign tx_udp_dest_port           = w_desc_q.dst_port;
  assign tx_udp_length              = w_desc_q.length;
  assign tx_udp_checksum            = 16'd0;
  assign tx_udp_payload_axis_tdata  = r_tdata;
  assign tx_udp_payload_axis_tvalid = r_tvalid;
  assign tx_udp_payload_axis_tlast  = r_tlast;
  assign tx_udp_payload_axis_tuser  = 1'b0;

`ifdef UDP_FRAME_BUILDER_STATS_EN
  logic [31:0] r_stat_sent;
  logic [31:0] r_stat_dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_sent    <= '0;
      r_stat_dropped <= '0;
    end else begin
      if (w_out_fire && r_tlast && (r_stat_sent != '1))
        r_stat_sent <= r_stat_sent + 32'd1;
      if (((w_status == STATUS_BAD) || (w_status == STATUS_OVERFLOW)) &&
          (r_stat_dropped != '1))
        r_stat_dropped <= r_stat_dropped + 32'd1;
    end
  end

  assign stat_frames_sent    = r_stat_sent;
  assign stat_frames_dropped = r_stat_dropped;
`endif

endmodule
